csr_file: RTL and testbench

- Machine-mode CSR register file and trap unit for the 3-stage pipeline.
- Acts on the decoder's csr_rd, csr_wr and is_mret strobes, and returns CSR read data for write-back.
- Detects timer and external interrupts, and redirects the PC to the trap vector (interrupt) or to mepc (mret).
- Sits in the execute/memory stage, beside the data memory.

---
 rtl/csr_pkg.sv | 29 ++
 rtl/irq_sync.sv | 26 ++
 rtl/csr_file.sv | 198 +++++++++++++++++++
 tb/tb_csr_file.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR file.
//   - 12-bit CSR addresses (the counter addresses are used only when
//     CSR_COUNTERS_EN is defined)
//   - interrupt cause codes written to mcause
//   - bit positions of the stored fields inside mstatus, mie and mip
package csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam int CAUSE_MTI = 7;
    localparam int CAUSE_MEI = 11;

    localparam int BIT_MIE  = 3;
    localparam int BIT_MPIE = 7;
    localparam int BIT_MTIE = 7;
    localparam int BIT_MTIP = 7;
    localparam int BIT_MEIE = 11;
    localparam int BIT_MEIP = 11;

endpackage

// File: rtl/irq_sync.sv
// irq_sync: two-flop synchroniser for an asynchronous level input.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (both flops clear to 0)
//   d      in  asynchronous level input
//   q      out synchronised level, two clk cycles behind d
module irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file and interrupt/mret redirect unit.
// Optional build macro: CSR_COUNTERS_EN adds 64-bit mcycle/minstret counters
// at 0xB00/0xB80/0xB02/0xB82; without it those addresses are unimplemented.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid             stage holds a real instruction
//   pc                PC of the instruction in this stage
//   csr_addr          CSR address (inst[31:20])
//   csr_wdata         write data (CSRRW semantics)
//   csr_rd, csr_wr    read / write strobes from the decoder
//   is_mret           mret strobe from the decoder
//   timer_irq         level timer interrupt, already synchronous
//   ext_irq           level external interrupt, asynchronous
//   csr_rdata         combinational read data (0 when not reading a real CSR)
//   csr_illegal       access to an unimplemented address (informational)
//   epc_taken, epc    registered one-cycle PC redirect request and target
module csr_file
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid,
    input  logic [XLEN-1:0] pc,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            csr_rd,
    input  logic            csr_wr,
    input  logic            is_mret,
    input  logic            timer_irq,
    input  logic            ext_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    output logic            epc_taken,
    output logic [XLEN-1:0] epc
);

    logic            meip;
    logic            mstatus_mie, mstatus_mpie;
    logic            mie_mtie, mie_meie;
    logic [XLEN-1:2] mtvec_base;
    logic            mtvec_mode;
    logic [XLEN-1:0] mepc_q, mcause_q;

    logic [XLEN-1:0] rd_val;
    logic            addr_hit;
    logic            ext_pend, tmr_pend;
    logic            trap_take, mret_take, wr_en;
    logic [XLEN-1:0] trap_code, vec_base, trap_target;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, minstret_q;
    logic [63:0] mcycle_nxt, minstret_nxt;
`endif

    irq_sync u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ext_irq),
        .q     (meip)
    );

    // Address decode and read mux; addr_hit doubles as the "implemented" flag.
    always_comb begin
        rd_val   = '0;
        addr_hit = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS: begin
                rd_val[BIT_MIE]  = mstatus_mie;
                rd_val[BIT_MPIE] = mstatus_mpie;
            end
            ADDR_MIE: begin
                rd_val[BIT_MTIE] = mie_mtie;
                rd_val[BIT_MEIE] = mie_meie;
            end
            ADDR_MTVEC:  rd_val = {mtvec_base, 1'b0, mtvec_mode};
            ADDR_MEPC:   rd_val = mepc_q;
            ADDR_MCAUSE: rd_val = mcause_q;
            ADDR_MIP: begin
                rd_val[BIT_MTIP] = timer_irq;
                rd_val[BIT_MEIP] = meip;
            end
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    rd_val = mcycle_q[31:0];
            ADDR_MCYCLEH:   rd_val = mcycle_q[63:32];
            ADDR_MINSTRET:  rd_val = minstret_q[31:0];
            ADDR_MINSTRETH: rd_val = minstret_q[63:32];
`endif
            default: addr_hit = 1'b0;
        endcase
    end

    assign csr_rdata   = (csr_rd && addr_hit) ? rd_val : '0;
    assign csr_illegal = (csr_rd || csr_wr) && !addr_hit;

    assign ext_pend  = mstatus_mie && mie_meie && meip;
    assign tmr_pend  = mstatus_mie && mie_mtie && timer_irq;
    // mret has priority; a still-pending interrupt is retried against the restored MIE.
    assign trap_take = valid && (ext_pend || tmr_pend) && !is_mret;
    assign mret_take = valid && is_mret;
    // The trapped instruction is replayed after mret, so its write must not land now.
    assign wr_en     = valid && csr_wr && addr_hit && !trap_take;

    assign trap_code   = ext_pend ? XLEN'(CAUSE_MEI) : XLEN'(CAUSE_MTI);
    assign vec_base    = {mtvec_base, 2'b00};
    assign trap_target = mtvec_mode ? (vec_base + (trap_code << 2)) : vec_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec_base   <= RESET_MTVEC[XLEN-1:2];
            mtvec_mode   <= RESET_MTVEC[0];
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else begin
            if (wr_en) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        mstatus_mie  <= csr_wdata[BIT_MIE];
                        mstatus_mpie <= csr_wdata[BIT_MPIE];
                    end
                    ADDR_MIE: begin
                        mie_mtie <= csr_wdata[BIT_MTIE];
                        mie_meie <= csr_wdata[BIT_MEIE];
                    end
                    ADDR_MTVEC: begin
                        mtvec_base <= csr_wdata[XLEN-1:2];
                        mtvec_mode <= csr_wdata[0];
                    end
                    ADDR_MEPC:   mepc_q   <= {csr_wdata[XLEN-1:2], 2'b00};
                    ADDR_MCAUSE: mcause_q <= csr_wdata;
                    default: ;
                endcase
            end
            // Trap / mret updates come last so they win over a same-cycle write.
            if (trap_take) begin
                mepc_q       <= pc;
                mcause_q     <= {1'b1, trap_code[XLEN-2:0]};
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_take) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_taken <= 1'b0;
            epc       <= '0;
        end else begin
            epc_taken <= trap_take || mret_take;
            if (trap_take) begin
                epc <= trap_target;
            end else if (mret_take) begin
                epc <= mepc_q;
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // A write to one half replaces that half of the incremented value, so a
    // carry out of a freshly written low half still shows up next cycle.
    always_comb begin
        mcycle_nxt   = mcycle_q + 64'd1;
        minstret_nxt = minstret_q;
        if (valid && !trap_take) begin
            minstret_nxt = minstret_q + 64'd1;
        end
        if (wr_en) begin
            case (csr_addr)
                ADDR_MCYCLE:    mcycle_nxt[31:0]    = csr_wdata[31:0];
                ADDR_MCYCLEH:   mcycle_nxt[63:32]   = csr_wdata[31:0];
                ADDR_MINSTRET:  minstret_nxt[31:0]  = csr_wdata[31:0];
                ADDR_MINSTRETH: minstret_nxt[63:32] = csr_wdata[31:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_nxt;
            minstret_q <= minstret_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: self-checking bench for csr_file (RESET_MTVEC = 32'h80).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] pc = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_rd = 1'b0;
    logic        csr_wr = 1'b0;
    logic        is_mret = 1'b0;
    logic        timer_irq = 1'b0;
    logic        ext_irq = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        epc_taken;
    logic [31:0] epc;

    csr_file #(.XLEN(32), .RESET_MTVEC(32'h80)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (valid),
        .pc          (pc),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rd      (csr_rd),
        .csr_wr      (csr_wr),
        .is_mret     (is_mret),
        .timer_irq   (timer_irq),
        .ext_irq     (ext_irq),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .epc_taken   (epc_taken),
        .epc         (epc)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];   // expected redirect targets, oldest first

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] p, input logic [11:0] a,
                         input logic [31:0] wd, input logic rd, input logic wr, input logic mr);
        valid = v; pc = p; csr_addr = a; csr_wdata = wd;
        csr_rd = rd; csr_wr = wr; is_mret = mr;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        idle();
        timer_irq = 1'b0;
        ext_irq   = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Combinational read with valid=0, so no state changes.
    task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        drive(1'b0, 32'h0, a, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        check(name, csr_rdata, exp);
        check({name, "_illegal"}, 32'(csr_illegal), 32'h0);
    endtask

    task automatic write_csr(input logic [11:0] a, input logic [31:0] wd);
        drive(1'b1, 32'h100, a, wd, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
    endtask

    task automatic check_redirect(input string name, input logic taken, input logic [31:0] target);
        check({name, "_taken"}, 32'(epc_taken), 32'(taken));
        check({name, "_epc"}, epc, target);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_epc;
    logic        m_ext_hist[$];   // ext_irq pin as sampled at the last two edges
    logic        m_taken;

    task automatic m_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = 32'h80; m_mepc = 0; m_mcause = 0;
        m_epc = 0; m_taken = 0;
        m_ext_hist = '{1'b0, 1'b0};
    endtask

    function automatic logic m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return (timer_irq ? 32'h80 : 32'h0) | (m_ext_hist[1] ? 32'h800 : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one clock edge using the inputs now applied.
    task automatic m_step();
        logic        ext_p, tim_p;
        int          code;
        logic [31:0] base;
        ext_p   = m_mstatus[3] && m_mie[11] && m_ext_hist[1];
        tim_p   = m_mstatus[3] && m_mie[7] && timer_irq;
        m_taken = 1'b0;
        if (valid && (ext_p || tim_p) && !is_mret) begin
            code = ext_p ? 11 : 7;
            base = m_mtvec & ~32'h3;
            exp_q.push_back(m_mtvec[0] ? base + 32'(4 * code) : base);
            m_mepc    = pc;
            m_mcause  = 32'h8000_0000 | 32'(code);
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            m_taken   = 1'b1;
        end else if (valid && is_mret) begin
            exp_q.push_back(m_mepc);
            m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            m_taken   = 1'b1;
        end else if (valid && csr_wr) begin
            case (csr_addr)
                12'h300: m_mstatus = csr_wdata & 32'h88;
                12'h304: m_mie     = csr_wdata & 32'h880;
                12'h305: m_mtvec   = csr_wdata & ~32'h2;
                12'h341: m_mepc    = csr_wdata & ~32'h3;
                12'h342: m_mcause  = csr_wdata;
                default: ;
            endcase
        end
        m_ext_hist.push_front(ext_irq);
        void'(m_ext_hist.pop_back());
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_old;   // read during the write cycle
        logic [31:0] exp_new;   // read on the following cycle
        logic        exp_ill;
    } vec_t;

    vec_t vecs[9];

    logic [11:0] rnd_addrs[8];

    initial begin
        logic flush;

        vecs[0] = '{12'h341, 32'h0000_1237, 32'h0,        32'h0000_1234, 1'b0};
        vecs[1] = '{12'h7C0, 32'hFFFF_FFFF, 32'h0,        32'h0,         1'b1};
        vecs[2] = '{12'h300, 32'hFFFF_FFFF, 32'h0,        32'h88,        1'b0};
        vecs[3] = '{12'h305, 32'hFFFF_FFFF, 32'h80,       32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{12'h342, 32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{12'h344, 32'hFFFF_FFFF, 32'h0,        32'h0,         1'b0};
        vecs[6] = '{12'h300, 32'h0,         32'h88,       32'h0,         1'b0};
        vecs[7] = '{12'h304, 32'hFFFF_FFFF, 32'h0,        32'h880,       1'b0};
        vecs[8] = '{12'h301, 32'h1234_5678, 32'h0,        32'h0,         1'b1};
        rnd_addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0, 12'h301};

        // ---- reset state ----
        #2;
        check_redirect("in_reset", 1'b0, 32'h0);
        check("in_reset_rdata", csr_rdata, 32'h0);
        check("in_reset_illegal", 32'(csr_illegal), 32'h0);
        reset_dut();
        read_check("rst_mtvec", 12'h305, 32'h80);
        read_check("rst_mstatus", 12'h300, 32'h0);
        read_check("rst_mie", 12'h304, 32'h0);
        read_check("rst_mepc", 12'h341, 32'h0);
        read_check("rst_mcause", 12'h342, 32'h0);
        read_check("rst_mip", 12'h344, 32'h0);
        check_redirect("rst", 1'b0, 32'h0);

        // ---- table-driven write / read-back ----
        tick();
        foreach (vecs[i]) begin
            drive(1'b1, 32'h100, vecs[i].addr, vecs[i].wdata, 1'b1, 1'b1, 1'b0);
            #1;
            check($sformatf("vec%0d_rdw", i), csr_rdata, vecs[i].exp_old);
            check($sformatf("vec%0d_ill_wr", i), 32'(csr_illegal), 32'(vecs[i].exp_ill));
            tick();
            drive(1'b0, 32'h0, vecs[i].addr, 32'h0, 1'b1, 1'b0, 1'b0);
            #1;
            check($sformatf("vec%0d_read", i), csr_rdata, vecs[i].exp_new);
            check($sformatf("vec%0d_ill_rd", i), 32'(csr_illegal), 32'(vecs[i].exp_ill));
            tick();
        end

        // ---- external interrupt, vectored mode ----
        reset_dut();
        write_csr(12'h304, 32'h800);
        write_csr(12'h300, 32'h8);
        write_csr(12'h305, 32'h101);
        ext_irq = 1'b1;
        drive(1'b1, 32'h40, 12'h344, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        check("sync_mip0", csr_rdata, 32'h0);
        tick();
        check("sync_mip1", csr_rdata, 32'h0);
        check_redirect("sync1", 1'b0, 32'h0);
        tick();
        check("sync_mip2", csr_rdata, 32'h800);
        check_redirect("sync2", 1'b0, 32'h0);
        tick();
        check_redirect("ext_trap", 1'b1, 32'h12C);
        ext_irq = 1'b0;
        read_check("ext_mepc", 12'h341, 32'h40);
        read_check("ext_mcause", 12'h342, 32'h8000_000B);
        read_check("ext_mstatus", 12'h300, 32'h80);
        tick();
        check_redirect("ext_after", 1'b0, 32'h12C);
        tick();
        tick();
        drive(1'b1, 32'h50, 12'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        check_redirect("mret", 1'b1, 32'h40);
        read_check("mret_mstatus", 12'h300, 32'h88);
        tick();
        check_redirect("mret_after", 1'b0, 32'h40);

        // ---- timer + external together, then mret against a pending irq ----
        write_csr(12'h304, 32'h880);
        timer_irq = 1'b1;
        ext_irq   = 1'b1;
        repeat (3) tick();
        drive(1'b1, 32'h60, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check_redirect("both_trap", 1'b1, 32'h12C);
        read_check("both_mcause", 12'h342, 32'h8000_000B);
        read_check("both_mepc", 12'h341, 32'h60);
        tick();
        check_redirect("both_flush", 1'b0, 32'h12C);
        write_csr(12'h300, 32'h88);
        drive(1'b1, 32'h70, 12'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        check_redirect("mret_wins", 1'b1, 32'h60);
        read_check("mret_wins_mepc", 12'h341, 32'h60);
        read_check("mret_wins_mstatus", 12'h300, 32'h88);
        tick();
        drive(1'b1, 32'h80, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check_redirect("retake", 1'b1, 32'h12C);

        // ---- reset dropped while a redirect is showing ----
        rst_n = 1'b0;
        #1;
        check_redirect("async_rst", 1'b0, 32'h0);
        timer_irq = 1'b0;
        ext_irq   = 1'b0;
        read_check("arst_mstatus", 12'h300, 32'h0);
        read_check("arst_mie", 12'h304, 32'h0);
        read_check("arst_mtvec", 12'h305, 32'h80);
        read_check("arst_mepc", 12'h341, 32'h0);
        read_check("arst_mcause", 12'h342, 32'h0);
        read_check("arst_mip", 12'h344, 32'h0);
        rst_n = 1'b1;
        tick();

        // ---- counters ----
`ifdef CSR_COUNTERS_EN
        write_csr(12'hB00, 32'hFFFF_FFFF);
        read_check("mcycle_wr", 12'hB00, 32'hFFFF_FFFF);
        read_check("mcycleh_wr", 12'hB80, 32'h0);
        tick();
        read_check("mcycleh_carry", 12'hB80, 32'h1);
        read_check("mcycle_wrap", 12'hB00, 32'h0);
`else
        drive(1'b0, 32'h0, 12'hB00, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        check("no_cnt_rdata", csr_rdata, 32'h0);
        check("no_cnt_illegal", 32'(csr_illegal), 32'h1);
        drive(1'b1, 32'h0, 12'hB82, 32'h5, 1'b0, 1'b1, 1'b0);
        #1;
        check("no_cnt_wr_illegal", 32'(csr_illegal), 32'h1);
        tick();
        idle();
`endif

        // ---- randomized run against the model ----
        reset_dut();
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            check("rnd_taken", 32'(epc_taken), 32'(m_taken));
            if (m_taken) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rnd_epc: got %h expected a queued target, queue empty", epc);
                end else begin
                    m_epc = exp_q.pop_front();
                    check("rnd_epc", epc, m_epc);
                end
            end else begin
                check("rnd_epc_hold", epc, m_epc);
            end
            flush = m_taken;
            if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
            if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
            is_mret   = ($urandom_range(0, 7) == 0);
            csr_wr    = !is_mret && ($urandom_range(0, 1) == 1);
            csr_rd    = ($urandom_range(0, 1) == 1);
            valid     = !flush && ($urandom_range(0, 3) != 0);
            pc        = $urandom() & ~32'h3;
            csr_addr  = rnd_addrs[$urandom_range(0, 7)];
            csr_wdata = $urandom();
            #1;
            check("rnd_rdata", csr_rdata,
                  (csr_rd && m_impl(csr_addr)) ? m_read(csr_addr) : 32'h0);
            check("rnd_illegal", 32'(csr_illegal),
                  32'((csr_rd || csr_wr) && !m_impl(csr_addr)));
            m_step();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
